shader_mem_arbiter: RTL and testbench
=====================================

# shader_mem_arbiter

Arbitrates the single port of the 16-entry shader instruction memory between the execute unit's per-cycle instruction fetch and the host side (SPI command decoder loading or reading back the program). The block holds one buffered host request and grants it a memory slot when fetch is idle, when the display is blanking or paused, or when a starvation limit is reached. It sits between `shader_spi`/`shader_execute` and `shader_memory` inside `tiny_shader_top`.

## Interface
- `NUM_INSTR`, 16: instruction memory depth; address width `ADDR_W = $clog2(NUM_INSTR)`.
- `INSTR_W`, 8: instruction width.
- `STARVE_LIMIT`, 15: cycles a pending host request may wait before fetch is stalled for it; range 1..255.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous reset, active-high; one clock, reset is asynchronous and active-high.
- `pause_i` in 1: execute paused; host has priority.
- `blank_i` in 1: display blanking interval; host has priority.
- `fetch_req_i` in 1: execute unit requests an instruction this cycle.
- `fetch_addr_i` in `ADDR_W`: fetch address.
- `fetch_gnt_o` out 1: fetch slot granted this cycle; combinational.
- `fetch_data_o` out `INSTR_W`: instruction; valid when `fetch_gnt_o`.
- `host_valid_i` in 1, `host_ready_o` out 1: host request handshake.
- `host_we_i` in 1, `host_addr_i` in `ADDR_W`, `host_wdata_i` in `INSTR_W`: host request fields.
- `host_rvalid_o` out 1: one-cycle pulse with read data.
- `host_rdata_o` out `INSTR_W`: registered read data.
- `mem_addr_o` out `ADDR_W`, `mem_we_o` out 1, `mem_wdata_o` out `INSTR_W`: memory port; combinational.
- `mem_rdata_i` in `INSTR_W`: combinational read data from memory.

## Operation
- Host buffer: one entry (`pend`, addr, we, wdata). `host_ready_o = !pend`. A transfer occurs on `host_valid_i && host_ready_o`, which loads the buffer and sets `pend`.
- Slot selection, evaluated every cycle:
  - HOST if `pend && (pause_i || blank_i || !fetch_req_i || starve_cnt == STARVE_LIMIT)`.
  - Otherwise FETCH if `fetch_req_i`.
  - Otherwise IDLE.
- FETCH: `mem_addr_o = fetch_addr_i`, `fetch_gnt_o = 1`, `fetch_data_o = mem_rdata_i`, `mem_we_o = 0`.
- HOST write: `mem_addr_o/mem_wdata_o` come from the buffer and `mem_we_o = 1`. `pend` clears at the clock edge.
- HOST read: `mem_addr_o` comes from the buffer. `mem_rdata_i` is registered into `host_rdata_o` and `host_rvalid_o` is set for the next cycle. `pend` clears.
- IDLE: `mem_we_o = 0`, `mem_addr_o = 0`, `fetch_gnt_o = 0`.
- `starve_cnt` (8 bit):
  - Clears when `!pend` or in a HOST slot.
  - Otherwise increments, saturating at `STARVE_LIMIT`.
  - A fetch denied by starvation keeps `fetch_gnt_o = 0`; the execute unit holds its address and retries.
- `host_rdata_o` holds its last value between reads.

## Timing
- Reset values:
  - `pend = 0`, `starve_cnt = 0`.
  - `host_rvalid_o = 0`, `host_rdata_o = 0`.
  - `host_ready_o = 1`; no transfer is captured while `rst` is high.
  - Memory outputs follow the IDLE/FETCH mux combinationally.
- Fetch latency is 0: grant and data arrive in the request cycle.
- Host write accepted at edge N: the earliest commit is cycle N+1 (`mem_we_o` high). `host_ready_o` rises at N+2 at the earliest.
- Host read accepted at N: with an immediate slot, `host_rvalid_o` is high in cycle N+2.
- Host throughput is at most one request per 2 cycles; no accept is allowed in the same cycle the buffer drains.
- With a continuous fetch stream and no blank/pause, a pending request is serviced exactly `STARVE_LIMIT + 1` cycles after its accept edge.
- `pause_i`/`blank_i` act combinationally in the same cycle.
- An asynchronous `rst` mid-request drops the buffered request: it is not committed and no `host_rvalid_o` is produced.

## Structure
- `shader_pkg` holds `INSTR_W`, `NUM_INSTR`, `ADDR_W`, and the enum `slot_t` {`SLOT_IDLE`, `SLOT_FETCH`, `SLOT_HOST`} shared with `shader_execute` and `shader_spi`.
- Single module. The buffer, counter and slot mux are small enough that no sub-module is warranted.

## Test plan
- Idle fetch: `fetch_req_i = 1` at addr 5 with mem[5] = 0xA3 -> `fetch_gnt_o = 1`, `fetch_data_o = 0xA3` in the same cycle, every cycle.
- Host write during blank: `blank_i = 1`, fetch requesting, write addr 3 data 0x5C -> `mem_we_o` high in the next cycle with addr 3 and data 0x5C, `fetch_gnt_o = 0` in that cycle, mem[3] = 0x5C afterwards.
- Starvation: continuous fetch, blank/pause low, `STARVE_LIMIT = 15`, host write accepted at edge N -> exactly one HOST slot, at cycle N+16 with `fetch_gnt_o = 0`; fetch is granted in all other cycles.
- Host read: with fetch idle, read addr 9 (mem[9] = 0x7E) -> `host_rvalid_o` is a single-cycle pulse two cycles after accept with `host_rdata_o = 0x7E`, and `host_ready_o` is high again in that cycle.
- Back-to-back: `host_valid_i` held high for 4 writes with fetch idle -> one accept every 2 cycles, all 4 committed in order, `host_ready_o` low in each cycle a request is pending.
- Reset mid-operation: a write is pending under continuous fetch and `rst` pulses -> the memory location is unchanged, `pend = 0`, `host_ready_o = 1`, `host_rvalid_o = 0`.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared definitions for the tiny shader: instruction memory geometry and
// the memory-slot owner enum used by the arbiter, execute unit and SPI decoder.
package shader_pkg;

    localparam int INSTR_W   = 8;
    localparam int NUM_INSTR = 16;
    localparam int ADDR_W    = $clog2(NUM_INSTR);

    // Owner of the single instruction-memory port in a given cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FETCH = 2'd1,
        SLOT_HOST  = 2'd2
    } slot_t;

endpackage

// File: rtl/shader_mem_arbiter.sv
// Instruction-memory port arbiter: per-cycle execute fetch versus a single
// buffered host (SPI) request. The host gets the port whenever fetch is idle,
// during blanking/pause, or once it has waited STARVE_LIMIT cycles.
module shader_mem_arbiter #(
    parameter int NUM_INSTR    = shader_pkg::NUM_INSTR,
    parameter int INSTR_W      = shader_pkg::INSTR_W,
    parameter int STARVE_LIMIT = 15,
    localparam int ADDR_W      = $clog2(NUM_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause_i,
    input  logic               blank_i,
    input  logic               fetch_req_i,
    input  logic [ADDR_W-1:0]  fetch_addr_i,
    output logic               fetch_gnt_o,
    output logic [INSTR_W-1:0] fetch_data_o,
    input  logic               host_valid_i,
    output logic               host_ready_o,
    input  logic               host_we_i,
    input  logic [ADDR_W-1:0]  host_addr_i,
    input  logic [INSTR_W-1:0] host_wdata_i,
    output logic               host_rvalid_o,
    output logic [INSTR_W-1:0] host_rdata_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_we_o,
    output logic [INSTR_W-1:0] mem_wdata_o,
    input  logic [INSTR_W-1:0] mem_rdata_i
);

    import shader_pkg::slot_t;
    import shader_pkg::SLOT_IDLE;
    import shader_pkg::SLOT_FETCH;
    import shader_pkg::SLOT_HOST;

    // Starvation counter is 8 bits wide; the limit is compared at that width.
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    // Host request buffer
    logic               pend_reg,       pend_next;
    logic               buf_we_reg,     buf_we_next;
    logic [ADDR_W-1:0]  buf_addr_reg,   buf_addr_next;
    logic [INSTR_W-1:0] buf_wdata_reg,  buf_wdata_next;

    // Starvation counter and host read response
    logic [7:0]         starve_cnt_reg, starve_cnt_next;
    logic               rvalid_reg,     rvalid_next;
    logic [INSTR_W-1:0] rdata_reg,      rdata_next;

    logic               host_accept;
    slot_t              slot;

    // The buffer is single-entry, so the host may only hand over a request
    // while nothing is pending; this also forbids an accept in the drain cycle.
    assign host_ready_o  = !pend_reg;
    assign host_rvalid_o = rvalid_reg;
    assign host_rdata_o  = rdata_reg;

    // Slot selection: a pending host request wins whenever fetch can spare
    // the port or has been ahead of it for STARVE_LIMIT cycles.
    always_comb begin
        slot = SLOT_IDLE;
        if (pend_reg && (pause_i || blank_i || !fetch_req_i ||
                         starve_cnt_reg == STARVE_MAX)) begin
            slot = SLOT_HOST;
        end else if (fetch_req_i) begin
            slot = SLOT_FETCH;
        end
    end

    // Memory port and fetch response mux, driven purely from the current slot.
    always_comb begin
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_wdata_o  = '0;
        fetch_gnt_o  = 1'b0;
        fetch_data_o = '0;
        case (slot)
            SLOT_FETCH: begin
                mem_addr_o   = fetch_addr_i;
                fetch_gnt_o  = 1'b1;
                fetch_data_o = mem_rdata_i;
            end
            SLOT_HOST: begin
                mem_addr_o = buf_addr_reg;
                mem_we_o   = buf_we_reg;
                if (buf_we_reg) begin
                    mem_wdata_o = buf_wdata_reg;
                end
            end
            default: begin
            end
        endcase
    end

    // Next-state logic for the buffer, starvation counter and read response.
    always_comb begin
        host_accept     = host_valid_i && !pend_reg;
        pend_next       = pend_reg;
        buf_we_next     = buf_we_reg;
        buf_addr_next   = buf_addr_reg;
        buf_wdata_next  = buf_wdata_reg;
        starve_cnt_next = starve_cnt_reg;
        rvalid_next     = 1'b0;
        rdata_next      = rdata_reg;

        // Accept and service are mutually exclusive: accept needs an empty
        // buffer, service needs a full one.
        if (host_accept) begin
            pend_next      = 1'b1;
            buf_we_next    = host_we_i;
            buf_addr_next  = host_addr_i;
            buf_wdata_next = host_wdata_i;
        end else if (slot == SLOT_HOST) begin
            pend_next = 1'b0;
        end

        // Counts cycles a pending request has been passed over by fetch.
        if (!pend_reg || slot == SLOT_HOST) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end

        // A host read captures the memory's combinational data in its slot
        // and presents it as a one-cycle pulse; the data then holds.
        if (slot == SLOT_HOST && !buf_we_reg) begin
            rvalid_next = 1'b1;
            rdata_next  = mem_rdata_i;
        end
    end

    // State registers; reset discards any buffered request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg       <= 1'b0;
            buf_we_reg     <= 1'b0;
            buf_addr_reg   <= '0;
            buf_wdata_reg  <= '0;
            starve_cnt_reg <= '0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            pend_reg       <= pend_next;
            buf_we_reg     <= buf_we_next;
            buf_addr_reg   <= buf_addr_next;
            buf_wdata_reg  <= buf_wdata_next;
            starve_cnt_reg <= starve_cnt_next;
            rvalid_reg     <= rvalid_next;
            rdata_reg      <= rdata_next;
        end
    end

endmodule

// File: tb/tb_shader_mem_arbiter.sv
// Scoreboard bench for shader_mem_arbiter: stimulus pushes expected host
// commits/read responses; a negedge monitor pops and compares them.
module tb_shader_mem_arbiter;

    localparam int LIMIT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_i = 1'b0;
    logic       blank_i = 1'b0;
    logic       fetch_req_i = 1'b0;
    logic [3:0] fetch_addr_i = '0;
    logic       fetch_gnt_o;
    logic [7:0] fetch_data_o;
    logic       host_valid_i = 1'b0;
    logic       host_ready_o;
    logic       host_we_i = 1'b0;
    logic [3:0] host_addr_i = '0;
    logic [7:0] host_wdata_i = '0;
    logic       host_rvalid_o;
    logic [7:0] host_rdata_o;
    logic [3:0] mem_addr_o;
    logic       mem_we_o;
    logic [7:0] mem_wdata_o;
    logic [7:0] mem_rdata_i;

    shader_mem_arbiter #(
        .NUM_INSTR   (16),
        .INSTR_W     (8),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pause_i     (pause_i),
        .blank_i     (blank_i),
        .fetch_req_i (fetch_req_i),
        .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o (fetch_gnt_o),
        .fetch_data_o(fetch_data_o),
        .host_valid_i(host_valid_i),
        .host_ready_o(host_ready_o),
        .host_we_i   (host_we_i),
        .host_addr_i (host_addr_i),
        .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Instruction memory model: combinational read, write on clock edge.
    logic [7:0] mem [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA3, 8'h06, 8'h07,
                             8'h08, 8'h7E, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    assign mem_rdata_i = mem[mem_addr_o];
    always @(posedge clk) if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] addr; logic [7:0] data; int cyc; } wexp_t;
    typedef struct { logic [7:0] data; int cyc; } rexp_t;
    wexp_t wq[$];
    rexp_t rq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every host commit or read response must match the queue head.
    always @(negedge clk) begin
        wexp_t we;
        rexp_t re;
        if (!rst) begin
            if (mem_we_o) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write (cycle %0d)",
                             mem_addr_o, mem_wdata_o, cyc);
                end else begin
                    we = wq.pop_front();
                    $display("host write addr %0d data 0x%0h at cycle %0d", mem_addr_o, mem_wdata_o, cyc);
                    check("write_addr", 32'(mem_addr_o), 32'(we.addr));
                    check("write_data", 32'(mem_wdata_o), 32'(we.data));
                    check("write_cycle", cyc, we.cyc);
                    check("write_no_fetch_gnt", 32'(fetch_gnt_o), 0);
                end
            end
            if (host_rvalid_o) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata 0x%0h, required no response (cycle %0d)",
                             host_rdata_o, cyc);
                end else begin
                    re = rq.pop_front();
                    $display("host read data 0x%0h at cycle %0d", host_rdata_o, cyc);
                    check("read_data", 32'(host_rdata_o), 32'(re.data));
                    check("read_cycle", cyc, re.cyc);
                    check("read_ready_high", 32'(host_ready_o), 1);
                end
            end
        end
    end

    // Issue one host request; lat = cycles between first post-accept cycle and service.
    task automatic host_issue(input logic we, input logic [3:0] a, input logic [7:0] d,
                              input int lat, output int acc);
        int n;
        wexp_t w;
        rexp_t r;
        n = 0;
        @(negedge clk);
        while (!host_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready_o) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got host_ready_o 0, required 1 within 50 cycles");
        end
        host_valid_i = 1'b1;
        host_we_i    = we;
        host_addr_i  = a;
        host_wdata_i = d;
        acc = cyc + 1;
        if (we) begin
            w.addr = a; w.data = d; w.cyc = acc + lat;
            wq.push_back(w);
        end else begin
            r.data = d; r.cyc = acc + lat + 1;
            rq.push_back(r);
        end
        @(negedge clk);
        host_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (wq.size() != 0 || rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d writes %0d reads outstanding, required 0",
                     wq.size(), rq.size());
            wq.delete();
            rq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int prev;
        int n;
        logic [3:0] b_addr [4];
        logic [7:0] b_data [4];
        wexp_t w;
        b_addr[0] = 4'd1; b_addr[1] = 4'd2; b_addr[2] = 4'd4; b_addr[3] = 4'd6;
        b_data[0] = 8'h11; b_data[1] = 8'h22; b_data[2] = 8'h44; b_data[3] = 8'h66;

        // Reset state, and no capture while rst is high
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(host_ready_o), 1);
        check("rst_rvalid", 32'(host_rvalid_o), 0);
        check("rst_rdata", 32'(host_rdata_o), 0);
        check("rst_mem_we", 32'(mem_we_o), 0);
        check("rst_fetch_gnt", 32'(fetch_gnt_o), 0);
        check("rst_mem_addr", 32'(mem_addr_o), 0);
        host_valid_i = 1'b1; host_we_i = 1'b1; host_addr_i = 4'd2; host_wdata_i = 8'h99;
        repeat (2) @(negedge clk);
        check("rst_no_capture", 32'(host_ready_o), 1);
        host_valid_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_capture_mem", 32'(mem[2]), 32'h02);

        // Idle fetch: zero-latency grant every cycle
        fetch_req_i = 1'b1; fetch_addr_i = 4'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fetch_gnt", 32'(fetch_gnt_o), 1);
            check("fetch_data", 32'(fetch_data_o), 32'hA3);
            check("fetch_mem_addr", 32'(mem_addr_o), 5);
        end
        fetch_req_i = 1'b0;
        @(negedge clk);
        check("idle_gnt", 32'(fetch_gnt_o), 0);
        check("idle_mem_addr", 32'(mem_addr_o), 0);

        // Host write during blank while fetch requests
        blank_i = 1'b1; fetch_req_i = 1'b1; fetch_addr_i = 4'd5;
        host_issue(1'b1, 4'd3, 8'h5C, 0, acc);
        drain();
        check("blank_mem3", 32'(mem[3]), 32'h5C);
        check("blank_fetch_after", 32'(fetch_gnt_o), 1);
        blank_i = 1'b0;

        // Host read during pause while fetch requests
        pause_i = 1'b1;
        host_issue(1'b0, 4'd5, 8'hA3, 0, acc);
        drain();
        pause_i = 1'b0;

        // Starvation: continuous fetch, host serviced exactly LIMIT+1 after accept edge
        fetch_req_i = 1'b1; fetch_addr_i = 4'd5;
        host_issue(1'b1, 4'd12, 8'h3D, LIMIT, acc);
        for (int k = 0; k < 19; k++) begin
            if (cyc == acc + LIMIT) begin
                check("starve_gnt_host", 32'(fetch_gnt_o), 0);
            end else begin
                check("starve_gnt_fetch", 32'(fetch_gnt_o), 1);
                check("starve_fetch_data", 32'(fetch_data_o), 32'hA3);
            end
            @(negedge clk);
        end
        drain();
        check("starve_mem12", 32'(mem[12]), 32'h3D);

        // Host read with fetch idle
        fetch_req_i = 1'b0;
        host_issue(1'b0, 4'd9, 8'h7E, 0, acc);
        drain();
        check("read_pulse_end", 32'(host_rvalid_o), 0);
        check("read_data_hold", 32'(host_rdata_o), 32'h7E);

        // Back-to-back writes with host_valid_i held high
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!host_ready_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            host_we_i = 1'b1; host_addr_i = b_addr[k]; host_wdata_i = b_data[k];
            acc = cyc + 1;
            w.addr = b_addr[k]; w.data = b_data[k]; w.cyc = acc;
            wq.push_back(w);
            if (k > 0) check("b2b_interval", acc - prev, 2);
            prev = acc;
            host_valid_i = 1'b1;
            @(negedge clk);
            check("b2b_ready_low", 32'(host_ready_o), 0);
        end
        host_valid_i = 1'b0;
        drain();
        for (int k = 0; k < 4; k++) check("b2b_mem", 32'(mem[b_addr[k]]), 32'(b_data[k]));

        // Reset while a write is pending under continuous fetch
        fetch_req_i = 1'b1; fetch_addr_i = 4'd5;
        host_issue(1'b1, 4'd7, 8'hEE, LIMIT, acc);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        wq.delete();
        #1;
        check("rst_mid_ready", 32'(host_ready_o), 1);
        check("rst_mid_rvalid", 32'(host_rvalid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_mid_mem7", 32'(mem[7]), 32'h07);
        check("rst_mid_ready_after", 32'(host_ready_o), 1);
        check("rst_mid_rvalid_after", 32'(host_rvalid_o), 0);
        check("rst_mid_fetch", 32'(fetch_gnt_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
